// File: rtl/bus_handshake_sync.sv
// bus_handshake_sync
//   Moves one DATA_WIDTH word at a time from the i_IClk domain to the i_OClk domain
//   with a toggle request / toggle acknowledge (four-phase free, two-flop) handshake.
//   The source captures the word into a hold register and flips req. The destination
//   sees req through two flops and loads the quasi-static hold register. It then
//   returns ack, which reaches the source through two more flops.
//
// Configuration macro: BUS_HANDSHAKE_SYNC_ORDY_EN
//   undefined : o_oValid is a one-cycle pulse. ack is returned on the same edge.
//   defined   : i_oReady exists. o_oValid and o_oData hold until i_oReady is 1,
//               and ack is returned on that edge.
//
// Handshake semantics (both sides): a word moves on a clock edge where valid and
// ready are both 1. Valid is not gated by ready. The source must keep i_iData
// meaningful only on the accepting edge, because the hold register takes over from there.
//
// Ports
//   i_IClk, i_aIReset_N : source clock, asynchronous active-low reset
//   i_OClk, i_aOReset_N : destination clock, asynchronous active-low reset
//   i_iValid, i_iData   : source offer (i_IClk domain)
//   o_iReady            : source may hand over a word (i_IClk domain)
//   o_oValid, o_oData   : destination word (i_OClk domain)
//   i_oReady            : destination accepts (i_OClk domain, ORDY_EN builds only)
//
// Both resets are expected to be asserted together. A single-sided reset leaves
// req/ack inconsistent and is not supported.

`timescale 1ns/1ps

module bus_handshake_sync #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  i_IClk,
  input  logic                  i_aIReset_N,
  input  logic                  i_OClk,
  input  logic                  i_aOReset_N,
  input  logic                  i_iValid,
  input  logic [DATA_WIDTH-1:0] i_iData,
  output logic                  o_iReady,
  output logic                  o_oValid,
  output logic [DATA_WIDTH-1:0] o_oData
`ifdef BUS_HANDSHAKE_SYNC_ORDY_EN
  ,
  input  logic                  i_oReady
`endif
);

  // ---------------------------------------------------------------------------
  // Source domain (i_IClk)
  // ---------------------------------------------------------------------------
  logic                  req;
  logic                  ack_s1;
  logic                  ack_s2;
  logic                  ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] hold;

  // Destination-domain ack, read here only through ack_s1/ack_s2.
  logic                  ack;

  assign accept   = i_iValid & ready;
  assign o_iReady = ready;

  always_ff @(posedge i_IClk or negedge i_aIReset_N) begin
    if (!i_aIReset_N) begin
      req    <= 1'b0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      hold   <= RESET_VALUE;
      ready  <= 1'b0;
    end else begin
      ack_s1 <= ack;
      ack_s2 <= ack_s1;
      if (accept) begin
        // hold is not touched again until ack comes back, so the destination
        // samples a stable value.
        hold  <= i_iData;
        req   <= ~req;
        ready <= 1'b0;
      end else if (!ready && (ack_s2 == req)) begin
        // After reset this fires on the first edge because req and ack_s2 are both 0.
        ready <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Destination domain (i_OClk)
  // ---------------------------------------------------------------------------
  logic                  req_s1;
  logic                  req_s2;
  logic                  valid;
  logic                  req_pending;
  logic [DATA_WIDTH-1:0] data;

  // A new word is waiting whenever the synchronised req differs from our ack.
  // Only the equality matters, so both bits wrap freely.
  assign req_pending = req_s2 ^ ack;

  assign o_oValid = valid;
  assign o_oData  = data;

  always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
    if (!i_aOReset_N) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      ack    <= 1'b0;
      valid  <= 1'b0;
      data   <= RESET_VALUE;
    end else begin
      req_s1 <= req;
      req_s2 <= req_s1;
`ifdef BUS_HANDSHAKE_SYNC_ORDY_EN
      if (valid) begin
        // Hold the word until the consumer takes it. Only then release the source.
        if (i_oReady) begin
          valid <= 1'b0;
          ack   <= req_s2;
        end
      end else if (req_pending) begin
        valid <= 1'b1;
        data  <= hold;
      end
`else
      if (req_pending) begin
        // Deliver and acknowledge on the same edge. The equality of ack and
        // req_s2 on the next edge ends the pulse.
        valid <= 1'b1;
        data  <= hold;
        ack   <= req_s2;
      end else begin
        valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bus_handshake_sync.sv
`timescale 1ns/1ps

module tb_bus_handshake_sync;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic iclk;
  logic oclk;
  logic irst_n;
  logic orst_n;
  int   ihalf = 5;   // 100 MHz
  int   ohalf = 15;  // ~33 MHz

  initial begin
    iclk = 1'b0;
    forever #(ihalf) iclk = ~iclk;
  end

  // Offset so that the two clocks' rising edges never coincide with the initial periods.
  initial begin
    oclk = 1'b0;
    #2;
    forever #(ohalf) oclk = ~oclk;
  end

  logic       i_valid;
  logic [7:0] i_data;
  logic       o_iready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       ordy;

  bus_handshake_sync #(.DATA_WIDTH(8)) dut (
    .i_IClk      (iclk),
    .i_aIReset_N (irst_n),
    .i_OClk      (oclk),
    .i_aOReset_N (orst_n),
    .i_iValid    (i_valid),
    .i_iData     (i_data),
    .o_iReady    (o_iready),
    .o_oValid    (o_valid),
    .o_oData     (o_data)
`ifdef BUS_HANDSHAKE_SYNC_ORDY_EN
    ,
    .i_oReady    (ordy)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         valid_cnt = 0;
  int         cnt_3c = 0;
  int         oclk_edges = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge oclk) oclk_edges++;

  // A word is consumed when valid and the consumer's ready meet.
  always @(negedge oclk) begin
    if (o_valid && ordy) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        check("data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    if (o_data == 8'h3C) cnt_3c++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] d, output int accept_edge);
    int n;
    n = 0;
    accept_edge = 0;
    @(negedge iclk);
    i_valid = 1'b1;
    i_data  = d;
    while (!o_iready && n < 200) begin
      @(negedge iclk);
      n++;
    end
    if (!o_iready) begin
      check("send_timeout", 32'(o_iready), 32'd1);
      i_valid = 1'b0;
    end else begin
      exp_q.push_back(d);
      @(posedge iclk);
      accept_edge = oclk_edges;
      @(negedge iclk);
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!o_iready && n < 200) begin
      @(negedge iclk);
      n++;
    end
    check(tag, 32'(o_iready), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge oclk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ae;
    int n;
    int bad;
    int vc;
    int c3;
    int sent;

    irst_n  = 1'b0;
    orst_n  = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    ordy    = 1'b1;

    // Reset state.
    repeat (3) @(negedge iclk);
    check("rst_iready", 32'(o_iready), 32'd0);
    check("rst_ovalid", 32'(o_valid), 32'd0);
    check("rst_odata", 32'(o_data), 32'd0);
    irst_n = 1'b1;
    orst_n = 1'b1;
    check("iready_before_edge", 32'(o_iready), 32'd0);
    @(posedge iclk);
    #1;
    check("iready_first_edge", 32'(o_iready), 32'd1);

    // No traffic for 100 destination cycles.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge oclk);
      if (o_valid || o_data != 8'h00) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Single word, latency measured in destination edges after acceptance.
    vc = valid_cnt;
    send(8'hA5, ae);
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge oclk);
      n++;
    end
    check("a5_valid_seen", 32'(o_valid), 32'd1);
    check("a5_latency", 32'(oclk_edges - ae), 32'd3);
    check("a5_data", 32'(o_data), 32'hA5);
    wait_drain("a5_drain");
    wait_ready("a5_ready_back");
    check("a5_one_valid", 32'(valid_cnt - vc), 32'd1);

    // Offer while busy is ignored.
    send(8'h11, ae);
    c3 = cnt_3c;
    vc = valid_cnt;
    i_valid = 1'b1;
    i_data  = 8'h3C;
    n = 0;
    while (!o_iready && n < 200) begin
      @(negedge iclk);
      n++;
    end
    i_valid = 1'b0;
    check("busy_ready_back", 32'(o_iready), 32'd1);
    wait_drain("busy_drain");
    repeat (10) @(negedge oclk);
    check("busy_no_3c", 32'(cnt_3c - c3), 32'd0);
    check("busy_one_word", 32'(valid_cnt - vc), 32'd1);
    send(8'h3C, ae);
    wait_drain("reoffer_drain");
    check("reoffer_3c", 32'(o_data), 32'h3C);
    wait_ready("reoffer_ready");

    // Joint reset one destination cycle after a request toggle.
    wait_ready("jrst_pre_ready");
    @(negedge iclk);
    i_valid = 1'b1;
    i_data  = 8'h77;
    @(posedge iclk);
    @(negedge iclk);
    i_valid = 1'b0;
    @(posedge oclk);
    #1;
    irst_n = 1'b0;
    orst_n = 1'b0;
    vc = valid_cnt;
    repeat (3) @(negedge oclk);
    @(negedge iclk);
    irst_n = 1'b1;
    orst_n = 1'b1;
    repeat (50) @(negedge oclk);
    check("jrst_no_valid", 32'(valid_cnt - vc), 32'd0);
    check("jrst_iready", 32'(o_iready), 32'd1);

`ifdef BUS_HANDSHAKE_SYNC_ORDY_EN
    // Destination stalls for 20 cycles.
    ordy = 1'b0;
    send(8'h5A, ae);
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge oclk);
      n++;
    end
    check("ordy_valid", 32'(o_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge oclk);
      if (!(o_valid && o_data == 8'h5A && !o_iready)) bad++;
    end
    check("ordy_hold_stable", 32'(bad), 32'd0);
    @(posedge oclk);
    #1;
    ordy = 1'b1;
    @(posedge oclk);
    #1;
    check("ordy_valid_clear", 32'(o_valid), 32'd0);
    wait_drain("ordy_drain");
    wait_ready("ordy_ready_back");
`endif

    // Streaming 0..255 with a slow source and fast destination.
    ihalf = 20;  // 25 MHz
    ohalf = 4;   // 125 MHz
    repeat (5) @(negedge iclk);
    vc   = valid_cnt;
    sent = 0;
    n    = 0;
    @(negedge iclk);
    i_valid = 1'b1;
    i_data  = 8'h00;
    while (sent < 256 && n < 20000) begin
      if (o_iready) begin
        exp_q.push_back(i_data);
        sent++;
        @(posedge iclk);
        @(negedge iclk);
        i_data = 8'(sent);
      end else begin
        @(negedge iclk);
        n++;
      end
    end
    i_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd256);
    wait_drain("stream_drain");
    repeat (20) @(negedge oclk);
    check("stream_count", 32'(valid_cnt - vc), 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
